// File: rtl/csa_acc.sv
// Carry-save accumulator: operand pairs are folded into redundant sum/carry registers
// via a 4:2 compressor; a single carry-propagate add resolves the result after the last beat.
module csa_acc #(
    parameter int W_IN   = 16,
    parameter int W_ACC  = 40,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_op0,
    input  logic [W_IN-1:0]  in_op1,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_ACC-1:0] out_data,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic [1:0] {IDLE, ACC, RES, OUT} state_t;

    // Bits above the operand width, set when sign-extending a negative operand.
    localparam logic [W_ACC-1:0] HI_MASK = ~W_ACC'({W_IN{1'b1}});

    state_t           state;
    state_t           state_nxt;
    logic [W_ACC-1:0] s_q;
    logic [W_ACC-1:0] c_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W_ACC-1:0] x0;
    logic [W_ACC-1:0] x1;
    logic [W_ACC-1:0] s1;
    logic [W_ACC-1:0] c1;
    logic [W_ACC-1:0] s_nxt;
    logic [W_ACC-1:0] c_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    assign accept = in_valid & in_ready;

    always_comb begin
        x0 = W_ACC'(in_op0) | ((SIGNED != 0 && in_op0[W_IN-1]) ? HI_MASK : '0);
        x1 = W_ACC'(in_op1) | ((SIGNED != 0 && in_op1[W_IN-1]) ? HI_MASK : '0);
        s1    = s_q ^ c_q ^ x0;
        c1    = ((s_q & c_q) | (s_q & x0) | (c_q & x0)) << 1;
        s_nxt = s1 ^ c1 ^ x1;
        c_nxt = ((s1 & c1) | (s1 & x1) | (c1 & x1)) << 1;
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, ACC: if (accept) state_nxt = in_last ? RES : ACC;
                RES:       state_nxt = OUT;
                OUT:       if (out_ready) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, ACC: in_ready  = 1'b1;
            OUT:       out_valid = 1'b1;
            default:   ;
        endcase
    end

    // Redundant accumulator; cleared by abort or by the result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            c_q   <= '0;
            cnt_q <= '0;
        end else if (clr || (state == OUT && out_ready)) begin
            s_q   <= '0;
            c_q   <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            s_q   <= s_nxt;
            c_q   <= c_nxt;
            cnt_q <= cnt_inc;
        end
    end

    // Result registers survive an abort; only reset or a new resolve changes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_cnt  <= '0;
        end else if (state == RES && !clr) begin
            out_data <= s_q + c_q;
            out_cnt  <= cnt_q;
        end
    end

endmodule

// File: tb/tb_csa_acc.sv
// Randomised bench for csa_acc: unsigned, signed and narrow-wrap instances share one
// handshake stream and are compared against plain-arithmetic running sums.
module tb_csa_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [15:0] in_op0;
    logic [15:0] in_op1;

    logic        in_ready_u, in_ready_s, in_ready_n;
    logic        out_valid_u, out_valid_s, out_valid_n;
    logic [39:0] out_data_u, out_data_s;
    logic [7:0]  out_data_n;
    logic [7:0]  out_cnt_u, out_cnt_s, out_cnt_n;

    logic [39:0] refU;
    logic [39:0] refS;
    logic [7:0]  refN;
    int          refCnt;
    int          checkCount = 0;
    int          failCount = 0;

    always #5 clk = ~clk;

    csa_acc #(.W_IN(16), .W_ACC(40), .SIGNED(0), .CNT_W(8)) dut_u (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_op0(in_op0), .in_op1(in_op1), .in_last(in_last), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_data(out_data_u), .out_cnt(out_cnt_u));

    csa_acc #(.W_IN(16), .W_ACC(40), .SIGNED(1), .CNT_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_op0(in_op0), .in_op1(in_op1), .in_last(in_last), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_cnt(out_cnt_s));

    csa_acc #(.W_IN(8), .W_ACC(8), .SIGNED(0), .CNT_W(8)) dut_n (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_op0(in_op0[7:0]), .in_op1(in_op1[7:0]), .in_last(in_last), .out_valid(out_valid_n),
        .out_ready(out_ready), .out_data(out_data_n), .out_cnt(out_cnt_n));

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        refU   = '0;
        refS   = '0;
        refN   = '0;
        refCnt = 0;
    endtask

    // One beat, presented from a falling edge and held until the accumulator takes it.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic last);
        int     waited = 0;
        longint sa;
        longint sb;
        in_valid = 1'b1;
        in_op0   = a;
        in_op1   = b;
        in_last  = last;
        while (!in_ready_u && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) checkOutput("beat accept timeout", 64'(in_ready_u), 64'd1);
        @(posedge clk);
        sa     = $signed(a);
        sb     = $signed(b);
        refU   = refU + 40'(a) + 40'(b);
        refS   = refS + 40'(sa + sb);
        refN   = refN + a[7:0] + b[7:0];
        refCnt = (refCnt < 255) ? refCnt + 1 : 255;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitValid(input string tag);
        int waited = 0;
        while (!out_valid_u && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, " out_valid"}, 64'(out_valid_u), 64'd1);
    endtask

    // Compare the held result, stall the consumer while pushing ignored beats, then take it.
    task automatic collectResult(input int holdCycles, input string tag);
        logic [39:0] held;
        waitValid(tag);
        checkOutput({tag, " data unsigned"}, 64'(out_data_u), 64'(refU));
        checkOutput({tag, " data signed"}, 64'(out_data_s), 64'(refS));
        checkOutput({tag, " data narrow"}, 64'(out_data_n), 64'(refN));
        checkOutput({tag, " cnt"}, 64'(out_cnt_u), 64'(refCnt));
        checkOutput({tag, " cnt narrow"}, 64'(out_cnt_n), 64'(refCnt));
        checkOutput({tag, " valid others"}, 64'({out_valid_s, out_valid_n}), 64'd3);
        held = out_data_u;
        for (int i = 0; i < holdCycles; i++) begin
            in_valid = 1'b1;
            in_op0   = 16'($urandom);
            in_op1   = 16'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            checkOutput({tag, " hold valid"}, 64'(out_valid_u), 64'd1);
            checkOutput({tag, " hold in_ready"}, 64'({in_ready_u, in_ready_s, in_ready_n}), 64'd0);
            checkOutput({tag, " hold data"}, 64'(out_data_u), 64'(held));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, " released valid"}, 64'(out_valid_u), 64'd0);
        checkOutput({tag, " released in_ready"}, 64'(in_ready_u), 64'd1);
        modelReset();
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [39:0] saved;
        int          n;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        in_op0    = '0;
        in_op1    = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", 64'(in_ready_u), 64'd1);
        checkOutput("reset out_valid", 64'(out_valid_u), 64'd0);
        checkOutput("reset out_data", 64'(out_data_u), 64'd0);
        checkOutput("reset out_cnt", 64'(out_cnt_u), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] unsigned sum and latency");
        applyStimulus(16'd3, 16'd5, 1'b0);
        applyStimulus(16'd7, 16'd9, 1'b1);
        checkOutput("latency edge t+1", 64'(out_valid_u), 64'd0);
        @(negedge clk);
        checkOutput("latency edge t+2", 64'(out_valid_u), 64'd1);
        checkOutput("sum 24", 64'(out_data_u), 64'd24);
        checkOutput("cnt 2", 64'(out_cnt_u), 64'd2);
        collectResult(0, "basic");

        $display("[TB] signed extension");
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b1);
        waitValid("signed");
        checkOutput("signed 0x7FFE", 64'(out_data_s), 64'h7FFE);
        collectResult(0, "signed");

        $display("[TB] narrow wrap and consumer stall");
        applyStimulus(16'h00FF, 16'h00FF, 1'b0);
        applyStimulus(16'h0002, 16'h0000, 1'b1);
        waitValid("wrap");
        checkOutput("wrap to 0", 64'(out_data_n), 64'd0);
        checkOutput("wrap cnt", 64'(out_cnt_n), 64'd2);
        collectResult(5, "wrap");
        applyStimulus(16'd100, 16'd23, 1'b1);
        collectResult(0, "after stall");

        $display("[TB] abort between beats and in output");
        for (int i = 0; i < 3; i++) applyStimulus(16'(i + 11), 16'(i * 7), 1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        modelReset();
        checkOutput("clr mid valid", 64'(out_valid_u), 64'd0);
        checkOutput("clr mid in_ready", 64'(in_ready_u), 64'd1);
        applyStimulus(16'd4, 16'd4, 1'b1);
        waitValid("clr mid");
        checkOutput("clr mid sum 8", 64'(out_data_u), 64'd8);
        checkOutput("clr mid cnt 1", 64'(out_cnt_u), 64'd1);
        collectResult(0, "clr mid");
        applyStimulus(16'd500, 16'd20, 1'b0);
        applyStimulus(16'd1, 16'd2, 1'b1);
        waitValid("clr out");
        saved     = out_data_u;
        clr       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        out_ready = 1'b0;
        modelReset();
        checkOutput("clr out valid", 64'(out_valid_u), 64'd0);
        checkOutput("clr out data kept", 64'(out_data_u), 64'(saved));
        applyStimulus(16'd4, 16'd4, 1'b1);
        waitValid("clr out next");
        checkOutput("clr out sum 8", 64'(out_data_u), 64'd8);
        collectResult(0, "clr out next");

        $display("[TB] reset mid accumulation and in output");
        applyStimulus(16'd10, 16'd20, 1'b0);
        applyStimulus(16'd30, 16'd40, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst mid in_ready", 64'(in_ready_u), 64'd1);
        checkOutput("rst mid out_data", 64'(out_data_u), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        applyStimulus(16'd1, 16'd2, 1'b1);
        collectResult(0, "rst mid next");
        applyStimulus(16'd9, 16'd9, 1'b1);
        waitValid("rst out");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst out valid", 64'(out_valid_u), 64'd0);
        checkOutput("rst out data", 64'(out_data_u), 64'd0);
        checkOutput("rst out cnt", 64'(out_cnt_u), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();

        $display("[TB] random accumulations");
        for (int it = 0; it < 6; it++) begin
            n = (it == 0) ? 300 : (it == 1) ? 1 : $urandom_range(1, 300);
            for (int k = 0; k < n; k++) begin
                idleCycles($urandom_range(0, 2));
                applyStimulus(16'($urandom), 16'($urandom), k == n - 1);
            end
            if (it == 0) begin
                waitValid("saturate");
                checkOutput("cnt saturates 255", 64'(out_cnt_u), 64'd255);
            end
            collectResult($urandom_range(0, 3), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
